// File: rtl/sm_key_debouncer.sv
// Purpose : debounce raw push-buttons into a clean level, press/release strobes and a press-toggled level.
// Latency : a stable input change reaches keyState DEBOUNCE_CYCLES+1 edges after it enters the synchronizer.
// Backpressure: none; every output is a free-running registered level or a one-cycle strobe.
//
// Ports:
//   clkIn      - single clock, all state on its rising edge
//   rst_n      - synchronous reset, active low
//   keyRaw     - asynchronous raw key pins (polarity set by RAW_ACTIVE_LOW)
//   keyState   - debounced level per key, 1 = pressed
//   keyPress   - one-cycle strobe in the cycle keyState rises
//   keyRelease - one-cycle strobe in the cycle keyState falls
//   keyToggle  - level that flips on every accepted press
module sm_key_debouncer #(
  parameter int KEYS            = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RAW_ACTIVE_LOW  = 1,
  parameter int CNT_W           = 16
) (
  input  logic            clkIn,
  input  logic            rst_n,
  input  logic [KEYS-1:0] keyRaw,
  output logic [KEYS-1:0] keyState,
  output logic [KEYS-1:0] keyPress,
  output logic [KEYS-1:0] keyRelease,
  output logic [KEYS-1:0] keyToggle
);

  // Count value on which a pending change is accepted.
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Normalised input: 1 = pressed regardless of board polarity.
  logic [KEYS-1:0] w_p;
  assign w_p = (RAW_ACTIVE_LOW != 0) ? ~keyRaw : keyRaw;

  logic [KEYS-1:0]  r_s1;
  logic [KEYS-1:0]  r_s2;
  logic [KEYS-1:0]  r_state;
  logic [KEYS-1:0]  r_press;
  logic [KEYS-1:0]  r_release;
  logic [KEYS-1:0]  r_toggle;
  logic [CNT_W-1:0] r_cnt [KEYS];

  always_ff @(posedge clkIn) begin
    if (!rst_n) begin
      // Synchronizer loads "released" so leaving reset cannot fake a change.
      r_s1      <= '0;
      r_s2      <= '0;
      r_state   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_toggle  <= '0;
      for (int k = 0; k < KEYS; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      r_s1      <= w_p;
      r_s2      <= r_s1;
      r_press   <= '0;
      r_release <= '0;
      for (int k = 0; k < KEYS; k++) begin
        if (r_s2[k] == r_state[k]) begin
          // Input agrees with the accepted level: any bounce restarts qualification.
          r_cnt[k] <= '0;
        end else if (r_cnt[k] >= LP_LAST) begin
          // Stable for the full window: accept, strobe in the same cycle.
          r_state[k]   <= r_s2[k];
          r_cnt[k]     <= '0;
          r_press[k]   <= r_s2[k];
          r_release[k] <= ~r_s2[k];
          if (r_s2[k]) begin
            r_toggle[k] <= ~r_toggle[k];
          end
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign keyState   = r_state;
  assign keyPress   = r_press;
  assign keyRelease = r_release;
  assign keyToggle  = r_toggle;

endmodule

// File: tb/tb_sm_key_debouncer.sv
// Purpose : exercise sm_key_debouncer with directed scenarios and random key activity.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sm_key_debouncer;

  localparam int KEYS = 4;
  localparam int D    = 4;

  logic            clkIn = 1'b0;
  logic            rst_n;
  logic [KEYS-1:0] keyRaw;
  logic [KEYS-1:0] keyState;
  logic [KEYS-1:0] keyPress;
  logic [KEYS-1:0] keyRelease;
  logic [KEYS-1:0] keyToggle;

  always #5 clkIn = ~clkIn;

  sm_key_debouncer #(
    .KEYS            (KEYS),
    .DEBOUNCE_CYCLES (D),
    .RAW_ACTIVE_LOW  (1),
    .CNT_W           (16)
  ) u_dut (
    .clkIn      (clkIn),
    .rst_n      (rst_n),
    .keyRaw     (keyRaw),
    .keyState   (keyState),
    .keyPress   (keyPress),
    .keyRelease (keyRelease),
    .keyToggle  (keyToggle)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the pressed level travels through a two-edge delay, and a key
  // flips when the delayed level has disagreed with the accepted level on each of
  // the last D edges (history is forgotten on reset and on every acceptance).
  logic [KEYS-1:0] m_state, m_press, m_rel, m_tog, m_d1, m_d2;
  logic [D-1:0]    m_win [KEYS];

  task automatic model_step();
    logic [KEYS-1:0] delayed;
    if (!rst_n) begin
      m_state = '0; m_press = '0; m_rel = '0; m_tog = '0; m_d1 = '0; m_d2 = '0;
      for (int k = 0; k < KEYS; k++) m_win[k] = '0;
    end else begin
      delayed = m_d2;
      m_press = '0;
      m_rel   = '0;
      for (int k = 0; k < KEYS; k++) begin
        m_win[k] = {m_win[k][D-2:0], delayed[k] != m_state[k]};
        if (&m_win[k]) begin
          m_state[k] = delayed[k];
          m_press[k] = delayed[k];
          m_rel[k]   = ~delayed[k];
          if (delayed[k]) m_tog[k] = ~m_tog[k];
          m_win[k] = '0;
        end
      end
      m_d2 = m_d1;
      m_d1 = ~keyRaw;
    end
  endtask

  int n_press [KEYS];
  int n_rel   [KEYS];

  task automatic clear_counts();
    for (int k = 0; k < KEYS; k++) begin
      n_press[k] = 0;
      n_rel[k]   = 0;
    end
  endtask

  // One clock: model advances on the edge, DUT compared 1 time unit later,
  // returns at the falling edge so the caller can drive the next inputs.
  task automatic tick();
    @(posedge clkIn);
    model_step();
    #1;
    chk("state",   32'(keyState),   32'(m_state));
    chk("press",   32'(keyPress),   32'(m_press));
    chk("release", 32'(keyRelease), 32'(m_rel));
    chk("toggle",  32'(keyToggle),  32'(m_tog));
    for (int k = 0; k < KEYS; k++) begin
      if (keyPress[k] === 1'b1)   n_press[k]++;
      if (keyRelease[k] === 1'b1) n_rel[k]++;
    end
    @(negedge clkIn);
  endtask

  // Ticks until keyPress[k] is seen (bounded); n = number of ticks, first one is E.
  task automatic wait_press(input int k, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (keyPress[k] !== 1'b1 && n < 30);
  endtask

  int n;
  int hold [KEYS];

  initial begin
    rst_n  = 1'b0;
    keyRaw = 4'hF;
    clear_counts();

    // 1: reset, then 20 idle cycles
    repeat (3) tick();
    rst_n = 1'b1;
    clear_counts();
    repeat (20) tick();
    chk("t1_state", 32'(keyState), 32'h0);
    chk("t1_strobes", 32'(n_press[0] + n_press[1] + n_press[2] + n_press[3] +
                          n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3]), 32'd0);

    // 2: clean press on key 0
    keyRaw[0] = 1'b0;
    wait_press(0, n);
    chk("t2_latency", 32'(n - 1), 32'd5);
    chk("t2_toggle", 32'(keyToggle[0]), 32'd1);
    tick();
    chk("t2_pulse_width", 32'(keyPress[0]), 32'd0);

    // 3: bouncing key 1, then held pressed
    clear_counts();
    for (int i = 0; i < 20; i++) begin
      keyRaw[1] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    keyRaw[1] = 1'b0;
    wait_press(1, n);
    chk("t3_latency", 32'(n - 1), 32'd5);
    repeat (5) tick();
    chk("t3_single_press", 32'(n_press[1]), 32'd1);

    // 4: short glitch on key 2
    clear_counts();
    keyRaw[2] = 1'b0;
    repeat (3) tick();
    keyRaw[2] = 1'b1;
    repeat (12) tick();
    chk("t4_state", 32'(keyState[2]), 32'd0);
    chk("t4_strobes", 32'(n_press[2] + n_rel[2]), 32'd0);

    // 5: press/release key 3 twice
    clear_counts();
    for (int r = 0; r < 2; r++) begin
      keyRaw[3] = 1'b0;
      repeat (10) tick();
      chk("t5_toggle", 32'(keyToggle[3]), (r == 0) ? 32'd1 : 32'd0);
      keyRaw[3] = 1'b1;
      repeat (10) tick();
    end
    chk("t5_releases", 32'(n_rel[3]), 32'd2);
    chk("t5_presses", 32'(n_press[3]), 32'd2);
    chk("t5_other_keys", 32'(n_press[0] + n_press[1] + n_press[2] +
                             n_rel[0] + n_rel[1] + n_rel[2]), 32'd0);

    // 6: reset in the middle of qualifying a key 0 press
    keyRaw[0] = 1'b1;
    repeat (10) tick();
    keyRaw[0] = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("t6_state_cleared", 32'(keyState), 32'h0);
    tick();
    rst_n = 1'b1;
    wait_press(0, n);
    chk("t6_latency", 32'(n - 1), 32'd5);

    // Random activity: mix of glitches and long holds, occasional reset
    for (int k = 0; k < KEYS; k++) hold[k] = $urandom_range(1, 12);
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < KEYS; k++) begin
        if (hold[k] == 0) begin
          keyRaw[k] = ~keyRaw[k];
          hold[k] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, D - 1)
                                                : $urandom_range(D + 2, D + 12);
        end else begin
          hold[k]--;
        end
      end
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
